piso_flit_serializer: RTL and testbench
=======================================

Name: piso_flit_serializer

Overview:
Parallel-in/serial-out stage that feeds the link deserializer. It accepts one input_size-bit flit from the router output port over a valid/ready handshake. It then emits the flit as output_size-bit beats, least-significant slice first, so the downstream right-shifting SIPO register holds the original flit after the final beat. Per-beat valid plus first/last markers let the link side frame flits, and a stall input pauses the stream.

Parameters:
input_size, 32, flit width in bits.
output_size, 4, beat width in bits. input_size must be an integer multiple of output_size, with a ratio of at least 2.
beats (localparam), input_size/output_size, beats per flit (8 at defaults).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
flit_in  input  input_size  flit to serialize; sampled on accept.
flit_valid  input  1  flit_in is valid.
flit_ready  output  1  block can accept a flit this cycle.
out_stall  input  1  downstream cannot take a beat this cycle.
data_out  output  output_size  current beat.
out_valid  output  1  data_out holds a valid beat.
out_first  output  1  current beat is beat 0 of a flit.
out_last  output  1  current beat is beat beats-1 of a flit.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, shift register=0, beat counter=0, data_out=0, out_valid=0, out_first=0, out_last=0. flit_ready=0 while reset is high.
- Accept: occurs on a rising edge where flit_valid && flit_ready. flit_in is loaded into the shift register, the counter is cleared and state moves to SHIFT.
- States:
  - IDLE: out_valid=0 and flit_ready=1.
  - SHIFT: out_valid=1 and data_out=shift_reg[output_size-1:0].
- Beat timing: the first beat is visible in the cycle after the accepting edge (latency 1). A beat is consumed on each edge where out_valid && !out_stall. On consumption the shift register shifts right by output_size with zero fill, and the counter increments.
- Markers: out_first = SHIFT && counter==0. out_last = SHIFT && counter==beats-1.
- Stall: while out_stall=1, data_out, out_first, out_last and the counter hold their values. A stall may last any number of cycles. out_stall is ignored in IDLE.
- Leaving SHIFT: when the last beat is consumed, state goes to IDLE unless a new flit is accepted on the same edge.
- flit_ready (combinational) = !reset && (IDLE || (out_last && !out_stall)).
  - This allows back-to-back flits with no idle cycle, i.e. one flit every beats cycles.
  - If a flit is accepted on the last-beat edge, the new flit is loaded and the counter reset, and beat 0 of the new flit appears in the next cycle.
- flit_valid while flit_ready=0 is not accepted. The source must hold it; the block keeps no record of it.
- Reset mid-flit: the in-flight flit is discarded. The first flit after reset release starts at beat 0.
- data_out carries no X in any state. In IDLE it holds the value last shifted (zero after a complete flit).

Test Plan:
- After reset, apply flit_in=0x87654321 with flit_valid for 1 cycle and out_stall=0 -> over 8 consecutive cycles data_out=1,2,3,4,5,6,7,8. out_first is high only on the 1 beat, out_last only on the 8 beat, flit_ready=0 during beats 0-6.
- Two flits, 0xDEADBEEF then 0x0123ABCD, with flit_valid held -> 16 contiguous valid beats F,E,E,B,D,A,E,D,D,C,B,A,3,2,1,0. The second accept occurs on the edge where out_last=1, with no gap cycle.
- Stall: raise out_stall for 3 cycles while beat 3 is showing -> data_out=4 and out_valid=1 held for 4 cycles. The remaining beats 5..8 follow, and total flit duration is 11 cycles.
- Assert reset during beat 4 of 0xAAAA5555 -> out_valid=0 and data_out=0 immediately, before the next edge. After release, flit_ready=1, and a new flit 0x11111111 yields eight beats of 1.
- Hold flit_valid with 0xFFFFFFFF while a flit is mid-stream -> not accepted until out_last && !out_stall. The in-flight flit's beats are unchanged.
- Loopback: connect data_out to the 4-bit SIPO deserializer, clocked only on out_valid && !out_stall, and send 0xCAFEF00D -> after 8 beats the SIPO output equals 0xCAFEF00D.

Source files
------------

// File: rtl/piso_flit_serializer.sv
// Parallel-in/serial-out flit serializer: accepts one flit per handshake and emits it
// as output_size-bit beats, LSB slice first, with first/last markers and stall support.
module piso_flit_serializer #(
    parameter int input_size  = 32,
    parameter int output_size = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [input_size-1:0]  flit_in,
    input  logic                   flit_valid,
    output logic                   flit_ready,
    input  logic                   out_stall,
    output logic [output_size-1:0] data_out,
    output logic                   out_valid,
    output logic                   out_first,
    output logic                   out_last
);

    localparam int beats = input_size / output_size;
    localparam int CNT_W = $clog2(beats);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [input_size-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    at_last;
    logic                    accept;
    logic                    consume;

    always_comb begin
        at_last    = (state_q == SHIFT) && (cnt_q == CNT_W'(beats - 1));
        out_valid  = (state_q == SHIFT);
        out_first  = (state_q == SHIFT) && (cnt_q == '0);
        out_last   = at_last;
        data_out   = shift_q[output_size-1:0];
        // Ready on the last unstalled beat lets the next flit follow with no gap.
        flit_ready = !reset && ((state_q == IDLE) || (at_last && !out_stall));
        accept     = flit_valid && flit_ready;
        consume    = (state_q == SHIFT) && !out_stall;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SHIFT;
            shift_d = flit_in;
            cnt_d   = '0;
        end else if (consume) begin
            shift_d = shift_q >> output_size;
            if (at_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_flit_serializer.sv
// Scoreboard bench for piso_flit_serializer: expected beats are queued when a flit is
// handed over and popped as the serializer presents them.
module tb_piso_flit_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] flit_in = '0;
    logic        flit_valid = 1'b0;
    logic        flit_ready;
    logic        out_stall = 1'b0;
    logic [3:0]  data_out;
    logic        out_valid;
    logic        out_first;
    logic        out_last;

    typedef struct packed {
        logic [3:0] data;
        logic       first;
        logic       last;
    } beat_t;

    beat_t       sb[$];
    beat_t       exp;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sipo = '0;

    piso_flit_serializer #(.input_size(32), .output_size(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .flit_in    (flit_in),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .out_stall  (out_stall),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_first  (out_first),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // Downstream right-shifting deserializer used for the loopback check.
    always @(posedge clk) begin
        if (out_valid && !out_stall) sipo <= {data_out, sipo[31:4]};
    end

    task automatic push_flit(input logic [31:0] f);
        for (int i = 0; i < 8; i++) begin
            beat_t b;
            b.data  = f[i*4 +: 4];
            b.first = (i == 0);
            b.last  = (i == 7);
            sb.push_back(b);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_first, out_last, data_out, flit_ready} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_state: got v%b f%b l%b d%h rdy%b, want all 0",
                     out_valid, out_first, out_last, data_out, flit_ready);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({flit_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_release: got rdy%b v%b, want rdy1 v0", flit_ready, out_valid);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        flit_in = 32'h8765_4321;
        flit_valid = 1'b1;
        #1;
        n_cmp++;
        if (flit_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready_idle: got %b want 1", flit_ready);
        end
        push_flit(flit_in);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            flit_valid = 1'b0;
            #1;
            exp = sb.pop_front();
            n_cmp++;
            if ({out_valid, out_first, out_last, data_out, flit_ready} !==
                {1'b1, exp.first, exp.last, exp.data, exp.last}) begin
                n_err++;
                $display("FAIL single_beat%0d: got v%b f%b l%b d%h rdy%b, want v1 f%b l%b d%h rdy%b",
                         c, out_valid, out_first, out_last, data_out, flit_ready,
                         exp.first, exp.last, exp.data, exp.last);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, data_out} !== 5'b0) begin
            n_err++;
            $display("FAIL single_idle: got v%b d%h, want v0 d0", out_valid, data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] flits [2];
        int          idx;
        flits[0] = 32'hDEAD_BEEF;
        flits[1] = 32'h0123_ABCD;
        @(negedge clk);
        flit_in = flits[0];
        flit_valid = 1'b1;
        #1;
        push_flit(flit_in);
        idx = 1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp = sb.pop_front();
            n_cmp++;
            if ({out_valid, out_first, out_last, data_out} !==
                {1'b1, exp.first, exp.last, exp.data}) begin
                n_err++;
                $display("FAIL b2b_beat%0d: got v%b f%b l%b d%h, want v1 f%b l%b d%h",
                         c, out_valid, out_first, out_last, data_out,
                         exp.first, exp.last, exp.data);
            end
            if (idx < 2) begin
                flit_in = flits[idx];
                flit_valid = 1'b1;
                #1;
                n_cmp++;
                if (flit_ready !== exp.last) begin
                    n_err++;
                    $display("FAIL b2b_ready%0d: got %b want %b", c, flit_ready, exp.last);
                end
                if (exp.last) begin
                    push_flit(flit_in);
                    idx++;
                end
            end else begin
                flit_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, data_out} !== 5'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got v%b d%h, want v0 d0", out_valid, data_out);
        end
    endtask

    task automatic test_stall();
        logic stall;
        @(negedge clk);
        flit_in = 32'h8765_4321;
        flit_valid = 1'b1;
        #1;
        push_flit(flit_in);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            flit_valid = 1'b0;
            exp = sb[0];
            n_cmp++;
            if ({out_valid, out_first, out_last, data_out} !==
                {1'b1, exp.first, exp.last, exp.data}) begin
                n_err++;
                $display("FAIL stall_cycle%0d: got v%b f%b l%b d%h, want v1 f%b l%b d%h",
                         c, out_valid, out_first, out_last, data_out,
                         exp.first, exp.last, exp.data);
            end
            stall = (c >= 3 && c <= 5);
            out_stall = stall;
            if (!stall) void'(sb.pop_front());
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_duration: got v%b want v0 after 11 cycles", out_valid);
        end
        out_stall = 1'b1;
        #1;
        n_cmp++;
        if (flit_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_idle_ignored: got rdy%b want 1", flit_ready);
        end
        out_stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        flit_in = 32'hAAAA_5555;
        flit_valid = 1'b1;
        #1;
        push_flit(flit_in);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            flit_valid = 1'b0;
            exp = sb.pop_front();
            n_cmp++;
            if ({out_valid, out_first, out_last, data_out} !==
                {1'b1, exp.first, exp.last, exp.data}) begin
                n_err++;
                $display("FAIL rstmid_beat%0d: got v%b f%b l%b d%h, want v1 f%b l%b d%h",
                         c, out_valid, out_first, out_last, data_out,
                         exp.first, exp.last, exp.data);
            end
        end
        reset = 1'b1;
        #1;
        sb.delete();
        n_cmp++;
        if ({out_valid, out_first, out_last, data_out, flit_ready} !== 8'b0) begin
            n_err++;
            $display("FAIL rstmid_async: got v%b f%b l%b d%h rdy%b, want all 0",
                     out_valid, out_first, out_last, data_out, flit_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        flit_in = 32'h1111_1111;
        flit_valid = 1'b1;
        #1;
        n_cmp++;
        if ({flit_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL rstmid_release: got rdy%b v%b, want rdy1 v0", flit_ready, out_valid);
        end
        push_flit(flit_in);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            flit_valid = 1'b0;
            exp = sb.pop_front();
            n_cmp++;
            if ({out_valid, out_first, out_last, data_out} !==
                {1'b1, exp.first, exp.last, exp.data}) begin
                n_err++;
                $display("FAIL rstmid_new%0d: got v%b f%b l%b d%h, want v1 f%b l%b d%h",
                         c, out_valid, out_first, out_last, data_out,
                         exp.first, exp.last, exp.data);
            end
        end
    endtask

    task automatic test_hold_valid();
        logic stall;
        logic exp_ready;
        logic taken;
        @(negedge clk);
        flit_in = 32'h8765_4321;
        flit_valid = 1'b1;
        #1;
        push_flit(flit_in);
        taken = 1'b0;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            exp = sb[0];
            n_cmp++;
            if ({out_valid, out_first, out_last, data_out} !==
                {1'b1, exp.first, exp.last, exp.data}) begin
                n_err++;
                $display("FAIL hold_cycle%0d: got v%b f%b l%b d%h, want v1 f%b l%b d%h",
                         c, out_valid, out_first, out_last, data_out,
                         exp.first, exp.last, exp.data);
            end
            stall = (c == 7);
            out_stall = stall;
            if (!stall) void'(sb.pop_front());
            flit_valid = (c >= 2) && !taken;
            flit_in = flit_valid ? 32'hFFFF_FFFF : 32'h0;
            #1;
            if (flit_valid) begin
                exp_ready = exp.last && !stall;
                n_cmp++;
                if (flit_ready !== exp_ready) begin
                    n_err++;
                    $display("FAIL hold_ready%0d: got %b want %b", c, flit_ready, exp_ready);
                end
                if (exp_ready) begin
                    push_flit(32'hFFFF_FFFF);
                    taken = 1'b1;
                end
            end
        end
        @(negedge clk);
        flit_valid = 1'b0;
        out_stall = 1'b0;
        n_cmp++;
        if ({out_valid, data_out, taken} !== 6'b1) begin
            n_err++;
            $display("FAIL hold_end: got v%b d%h taken%b, want v0 d0 taken1", out_valid, data_out, taken);
        end
    endtask

    task automatic test_loopback();
        int taken;
        @(negedge clk);
        flit_in = 32'hCAFE_F00D;
        flit_valid = 1'b1;
        taken = 0;
        for (int c = 0; c < 60 && taken < 8; c++) begin
            @(negedge clk);
            flit_valid = 1'b0;
            out_stall = ($urandom_range(0, 1) == 1);
            if (out_valid && !out_stall) taken++;
        end
        @(negedge clk);
        out_stall = 1'b0;
        n_cmp++;
        if (taken !== 8) begin
            n_err++;
            $display("FAIL loopback_timeout: got %0d beats want 8", taken);
        end
        n_cmp++;
        if (sipo !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL loopback_sipo: got %h want cafef00d", sipo);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL loopback_idle: got v%b want v0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_hold_valid();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
